// File: rtl/switch_debounce_if.sv
// Switch conditioning bus: raw pins in, debounced level and edge pulses out.
// The optional event_count signal exists only when SW_EVENT_COUNT_EN is defined.
interface switch_debounce_if #(
  parameter int WIDTH = 2
);

  logic [WIDTH-1:0] sw_raw;
  logic [WIDTH-1:0] sw_clean;
  logic [WIDTH-1:0] sw_rise;
  logic [WIDTH-1:0] sw_fall;
`ifdef SW_EVENT_COUNT_EN
  logic [15:0]      event_count;
`endif

`ifdef SW_EVENT_COUNT_EN
  // Pin / firmware side: drives the raw switches, observes the clean results.
  modport master (
    output sw_raw,
    input  sw_clean,
    input  sw_rise,
    input  sw_fall,
    input  event_count
  );

  // Debouncer side.
  modport slave (
    input  sw_raw,
    output sw_clean,
    output sw_rise,
    output sw_fall,
    output event_count
  );
`else
  // Pin / firmware side: drives the raw switches, observes the clean results.
  modport master (
    output sw_raw,
    input  sw_clean,
    input  sw_rise,
    input  sw_fall
  );

  // Debouncer side.
  modport slave (
    input  sw_raw,
    output sw_clean,
    output sw_rise,
    output sw_fall
  );
`endif

endinterface

// File: rtl/switch_debounce.sv
// switch_debounce: conditions raw slide-switch pins for the PIO switch port.
// Each bit is synchronised through two flops and then debounced by its own
// two-state machine; accepted changes update sw_clean and fire a one-cycle
// sw_rise or sw_fall pulse in the same cycle.
// Optional feature macro: SW_EVENT_COUNT_EN adds a 16-bit wrapping count of
// accepted edges across all channels (event_count on the interface).
//
// Per-channel FSM:
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   ST_STABLE | synchronised input equals sw_clean; nothing pending
//   ST_CHECK  | input differs from sw_clean; counting how long it stays so
module switch_debounce #(
  parameter int WIDTH       = 2,
  parameter int CLK_HZ      = 50000000,
  parameter int DEBOUNCE_US = 10000
) (
  input  logic             clk_clk,
  input  logic             reset_reset_n,
  switch_debounce_if.slave sw_if
);

  // Number of consecutive CHECK cycles a new level must survive.
  localparam int CNT_MAX = CLK_HZ / 1000000 * DEBOUNCE_US;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_MAX - 1);

  localparam logic [0:0] ST_STABLE = 1'b0;
  localparam logic [0:0] ST_CHECK  = 1'b1;

  // A window of fewer than two cycles cannot be distinguished from no filtering.
  if (CNT_MAX < 2) begin : g_cnt_max_check
    $error("switch_debounce: CNT_MAX must be at least 2");
  end

  logic [WIDTH-1:0]            s1_q, s1_d;
  logic [WIDTH-1:0]            s2_q, s2_d;
  logic [WIDTH-1:0]            state_q, state_d;
  logic [WIDTH-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]            sw_clean_q, sw_clean_d;
  logic [WIDTH-1:0]            sw_rise_q, sw_rise_d;
  logic [WIDTH-1:0]            sw_fall_q, sw_fall_d;
  logic [WIDTH-1:0]            differs;

  // Two-flop synchroniser feed: only s2 is trusted downstream.
  always_comb begin
    s1_d = sw_if.sw_raw;
    s2_d = s1_q;
  end

  // Synchroniser flops.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
    end
  end

  assign differs = s2_q ^ sw_clean_q;

  // Per-channel debounce decision; pulses default low so they last one cycle.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    sw_clean_d = sw_clean_q;
    sw_rise_d  = '0;
    sw_fall_d  = '0;
    for (int i = 0; i < WIDTH; i++) begin
      case (state_q[i])
        ST_STABLE: begin
          if (differs[i]) begin
            state_d[i] = ST_CHECK;
            cnt_d[i]   = '0;
          end
        end
        ST_CHECK: begin
          if (!differs[i]) begin
            // Bounce: input returned before the window elapsed.
            state_d[i] = ST_STABLE;
          end else if (cnt_q[i] == CNT_LAST) begin
            sw_clean_d[i] = s2_q[i];
            sw_rise_d[i]  = s2_q[i];
            sw_fall_d[i]  = ~s2_q[i];
            state_d[i]    = ST_STABLE;
          end else begin
            cnt_d[i] = cnt_q[i] + CNT_W'(1);
          end
        end
        default: begin
          state_d[i] = ST_STABLE;
        end
      endcase
    end
  end

  // FSM state, window counters and registered outputs.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_q    <= {WIDTH{ST_STABLE}};
      cnt_q      <= '0;
      sw_clean_q <= '0;
      sw_rise_q  <= '0;
      sw_fall_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sw_clean_q <= sw_clean_d;
      sw_rise_q  <= sw_rise_d;
      sw_fall_q  <= sw_fall_d;
    end
  end

  assign sw_if.sw_clean = sw_clean_q;
  assign sw_if.sw_rise  = sw_rise_q;
  assign sw_if.sw_fall  = sw_fall_q;

`ifdef SW_EVENT_COUNT_EN
  logic [15:0] event_count_q, event_count_d;
  logic [15:0] edge_sum;

  // Count the pulses currently on the outputs; 16-bit add wraps naturally.
  always_comb begin
    edge_sum = '0;
    for (int i = 0; i < WIDTH; i++) begin
      edge_sum = edge_sum + 16'(sw_rise_q[i] | sw_fall_q[i]);
    end
    event_count_d = event_count_q + edge_sum;
  end

  // Event counter register.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      event_count_q <= '0;
    end else begin
      event_count_q <= event_count_d;
    end
  end

  assign sw_if.event_count = event_count_q;
`endif

endmodule

// File: tb/tb_switch_debounce.sv
// Testbench for switch_debounce (CNT_MAX = 8, so a clean step shows up on
// sw_clean 11 edges after it is first sampled). The reference model accepts
// a new level once the synchronised input has disagreed with the clean level
// for CNT_MAX+1 consecutive cycles.
module tb_switch_debounce;

  localparam int WIDTH   = 2;
  localparam int CNT_MAX = 8;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  switch_debounce_if #(.WIDTH(WIDTH)) sw_if ();

  switch_debounce #(
    .WIDTH      (WIDTH),
    .CLK_HZ     (1000000),
    .DEBOUNCE_US(8)
  ) dut (
    .clk_clk      (clk),
    .reset_reset_n(rst_n),
    .sw_if        (sw_if)
  );

`ifdef SW_EVENT_COUNT_EN
  // Wide, short-window instance used only to reach the counter wrap quickly.
  switch_debounce_if #(.WIDTH(16)) fast_if ();

  switch_debounce #(
    .WIDTH      (16),
    .CLK_HZ     (1000000),
    .DEBOUNCE_US(2)
  ) dut_fast (
    .clk_clk      (clk),
    .reset_reset_n(rst_n),
    .sw_if        (fast_if)
  );
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state.
  logic [WIDTH-1:0] m_s1, m_s2, m_clean, m_rise, m_fall;
  int               m_run [WIDTH];
  logic [15:0]      m_count;
  logic [WIDTH-1:0] seen;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_s1 = '0; m_s2 = '0; m_clean = '0; m_rise = '0; m_fall = '0;
    m_count = '0;
    for (int i = 0; i < WIDTH; i++) m_run[i] = 0;
  endtask

  task automatic model_update();
    if (!rst_n) begin
      model_reset();
    end else begin
      m_count = m_count + 16'($countones(m_rise | m_fall));
      m_rise = '0;
      m_fall = '0;
      for (int i = 0; i < WIDTH; i++) begin
        if (m_s2[i] != m_clean[i]) begin
          m_run[i]++;
          if (m_run[i] == CNT_MAX + 1) begin
            m_clean[i] = m_s2[i];
            m_rise[i]  = m_s2[i];
            m_fall[i]  = ~m_s2[i];
            m_run[i]   = 0;
          end
        end else begin
          m_run[i] = 0;
        end
      end
      m_s2 = m_s1;
      m_s1 = sw_if.sw_raw;
    end
  endtask

  // One clock: advance the model on the edge, compare on the falling edge.
  task automatic tick();
    @(posedge clk);
    model_update();
    @(negedge clk);
    chk("clean", 32'(sw_if.sw_clean), 32'(m_clean));
    chk("rise", 32'(sw_if.sw_rise), 32'(m_rise));
    chk("fall", 32'(sw_if.sw_fall), 32'(m_fall));
    chk("rise_fall_excl", 32'(sw_if.sw_rise & sw_if.sw_fall), 32'd0);
`ifdef SW_EVENT_COUNT_EN
    chk("event_count", 32'(sw_if.event_count), 32'(m_count));
`endif
    seen = seen | sw_if.sw_rise | sw_if.sw_fall;
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic async_reset(input int hold);
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("rst_clean", 32'(sw_if.sw_clean), 32'd0);
    chk("rst_pulses", 32'(sw_if.sw_rise | sw_if.sw_fall), 32'd0);
    @(negedge clk);
    ticks(hold);
    rst_n = 1'b1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    seen     = '0;
    rst_n    = 1'b0;
    sw_if.sw_raw = 2'b00;
`ifdef SW_EVENT_COUNT_EN
    fast_if.sw_raw = '0;
`endif
    model_reset();

    // 1: reset state, then quiet input produces nothing.
    #3;
    chk("t1_reset_clean", 32'(sw_if.sw_clean), 32'd0);
    chk("t1_reset_pulses", 32'(sw_if.sw_rise | sw_if.sw_fall), 32'd0);
    @(negedge clk);
    ticks(2);
    rst_n = 1'b1;
    seen = '0;
    ticks(50);
    chk("t1_no_pulses", 32'(seen), 32'd0);

    // 2: bit 0 step up appears on the 11th edge with one rise pulse.
    sw_if.sw_raw = 2'b01;
    ticks(10);
    chk("t2_clean_before", 32'(sw_if.sw_clean[0]), 32'd0);
    tick();
    chk("t2_clean_at11", 32'(sw_if.sw_clean[0]), 32'd1);
    chk("t2_rise_at11", 32'(sw_if.sw_rise[0]), 32'd1);
    tick();
    chk("t2_rise_gone", 32'(sw_if.sw_rise[0]), 32'd0);

    // 3: short toggles on bit 1 are rejected.
    seen = '0;
    sw_if.sw_raw = 2'b11; ticks(3);
    sw_if.sw_raw = 2'b01; ticks(3);
    sw_if.sw_raw = 2'b11; ticks(3);
    sw_if.sw_raw = 2'b01; ticks(30);
    chk("t3_clean1", 32'(sw_if.sw_clean[1]), 32'd0);
    chk("t3_pulse1", 32'(seen[1]), 32'd0);

    // 4: both rise, bit 1 bounces once; each settles on its own schedule.
    sw_if.sw_raw = 2'b00; ticks(20);
    sw_if.sw_raw = 2'b11; ticks(4);
    sw_if.sw_raw = 2'b01; ticks(1);
    sw_if.sw_raw = 2'b11; ticks(5);
    chk("t4_b0_before", 32'(sw_if.sw_clean), 32'd0);
    tick();
    chk("t4_b0_at11", 32'(sw_if.sw_clean), 32'd1);
    chk("t4_b0_rise", 32'(sw_if.sw_rise), 32'd1);
    ticks(4);
    chk("t4_b1_before", 32'(sw_if.sw_clean[1]), 32'd0);
    tick();
    chk("t4_b1_at11", 32'(sw_if.sw_clean[1]), 32'd1);
    chk("t4_b1_rise", 32'(sw_if.sw_rise[1]), 32'd1);

    // 5: reset 6 cycles into a CHECK aborts it; raw held high re-triggers after release.
    sw_if.sw_raw = 2'b10; ticks(25);
    chk("t5_pre_clean", 32'(sw_if.sw_clean), 32'd2);
    sw_if.sw_raw = 2'b11; ticks(9);
    async_reset(3);
    ticks(10);
    chk("t5_clean_before", 32'(sw_if.sw_clean), 32'd0);
    tick();
    chk("t5_clean_at11", 32'(sw_if.sw_clean), 32'd3);
    chk("t5_rise_at11", 32'(sw_if.sw_rise), 32'd3);

    // 6: three edges on bit 0, two on bit 1.
    sw_if.sw_raw = 2'b00;
    async_reset(2);
    ticks(20);
    sw_if.sw_raw = 2'b11; ticks(15);
    sw_if.sw_raw = 2'b00; ticks(15);
    sw_if.sw_raw = 2'b01; ticks(15);
    chk("t6_clean", 32'(sw_if.sw_clean), 32'd1);
`ifdef SW_EVENT_COUNT_EN
    chk("t6_event_count", 32'(sw_if.event_count), 32'd5);
`endif

    // Random bouncing on both bits, with one mid-run reset.
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 6) == 0) sw_if.sw_raw[0] = ~sw_if.sw_raw[0];
      if ($urandom_range(0, 6) == 0) sw_if.sw_raw[1] = ~sw_if.sw_raw[1];
      if (n == 700) async_reset(2);
      tick();
    end

`ifdef SW_EVENT_COUNT_EN
    // Counter wrap: 16 channels toggled 4095 times, then 15 more edges reach 0xFFFF.
    async_reset(2);
    for (int k = 0; k < 4095; k++) begin
      fast_if.sw_raw = ~fast_if.sw_raw;
      repeat (4) @(negedge clk);
    end
    fast_if.sw_raw = fast_if.sw_raw ^ 16'h7FFF;
    repeat (10) @(negedge clk);
    chk("t6_wrap_ffff", 32'(fast_if.event_count), 32'h0000FFFF);
    fast_if.sw_raw = fast_if.sw_raw ^ 16'h8000;
    repeat (10) @(negedge clk);
    chk("t6_wrap_zero", 32'(fast_if.event_count), 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
